alu_seq16: RTL

- Sequences the shared 8-bit ALU to perform the CPU's 16-bit arithmetic: ADD HL,rr; ADD SP,e8; INC rr; DEC rr.
- Each operation takes two byte passes over consecutive M-cycles: a low-byte ADD, then a high-byte ADC.
- Sits between the instruction decoder, which issues requests, and the alu instance, which it drives.
- Assembles the 16-bit result and the final F-register value for register-file writeback.

---
 rtl/gate_boy_pkg.sv | 53 +++++
 rtl/alu_seq16.sv | 138 +++++++++++++
 2 files changed

// File: rtl/gate_boy_pkg.sv
// rtl/gate_boy_pkg.sv - shared CPU types: ALU opcodes, flag indices, 16-bit sequencer ops and states
package gate_boy_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int FLAG_WIDTH = 8;

  localparam int FLAG_Z = 7;
  localparam int FLAG_N = 6;
  localparam int FLAG_H = 5;
  localparam int FLAG_C = 4;

  typedef enum logic [3:0] {
    NOP    = 4'd0,
    ADD    = 4'd1,
    ADC    = 4'd2,
    SUB    = 4'd3,
    SBC    = 4'd4,
    AND_OP = 4'd5,
    XOR_OP = 4'd6,
    OR_OP  = 4'd7,
    CP     = 4'd8
  } instruction_t;

  typedef enum logic [1:0] {
    ADD16 = 2'd0,
    ADDSP = 2'd1,
    INC16 = 2'd2,
    DEC16 = 2'd3
  } seq16_op_t;

  localparam logic [1:0] SEQ16_IDLE = 2'd0;
  localparam logic [1:0] SEQ16_LO   = 2'd1;
  localparam logic [1:0] SEQ16_HI   = 2'd2;
  localparam logic [1:0] SEQ16_FIN  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = SEQ16_IDLE,
    ST_LO   = SEQ16_LO,
    ST_HI   = SEQ16_HI,
    ST_FIN  = SEQ16_FIN
  } seq16_state_t;

  // Second addend as seen by the two byte passes; ADDSP sign-extends e8.
  function automatic logic [15:0] seq16_operand_b(input seq16_op_t op, input logic [15:0] b);
    case (op)
      ADD16:   return b;
      ADDSP:   return {{8{b[7]}}, b[7:0]};
      INC16:   return 16'h0001;
      default: return 16'hFFFF;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq16.sv
// rtl/alu_seq16.sv - drives the shared 8-bit ALU through ADD/ADC byte passes for 16-bit ops
module alu_seq16
  import gate_boy_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  phi_en,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  seq16_op_t             req_op,
  input  logic [15:0]           req_a,
  input  logic [15:0]           req_b,
  input  logic [FLAG_WIDTH-1:0] flags_in,
  output logic [DATA_WIDTH-1:0] alu_operand_A,
  output logic [DATA_WIDTH-1:0] alu_operand_B,
  output instruction_t          alu_opcode,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [FLAG_WIDTH-1:0] alu_flags,
  output logic                  done,
  output logic [15:0]           result16,
  output logic [FLAG_WIDTH-1:0] flags_out,
  output logic                  flags_we
);

  seq16_state_t          state, state_n;
  logic                  accept;
  seq16_op_t             op_q;
  logic [15:0]           a_q, b_q;
  logic [DATA_WIDTH-1:0] lo_q;
  logic                  lo_h_q, lo_c_q;
  logic [FLAG_WIDTH-1:0] fin_flags;
  logic                  fin_we;
  logic                  unused_bits;

  assign unused_bits = ^{flags_in[3:0], alu_flags[FLAG_Z], alu_flags[FLAG_N], alu_flags[3:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else if (phi_en) begin
      state <= state_n;
    end
  end

  // ALU drive is purely a function of state so it is stable across the whole M-cycle.
  always_comb begin
    state_n       = state;
    accept        = 1'b0;
    alu_opcode    = NOP;
    alu_operand_A = '0;
    alu_operand_B = '0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_n = ST_LO;
        end
      end
      ST_LO: begin
        alu_opcode    = ADD;
        alu_operand_A = a_q[7:0];
        alu_operand_B = b_q[7:0];
        state_n       = ST_HI;
      end
      ST_HI: begin
        alu_opcode    = ADC;
        alu_operand_A = a_q[15:8];
        alu_operand_B = b_q[15:8];
        state_n       = ST_FIN;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign req_ready = (state == ST_IDLE);

  // At FIN the alu still holds the high-pass flags; ADDSP reports the low pass instead.
  always_comb begin
    fin_flags = flags_in;
    fin_we    = 1'b0;
    case (op_q)
      ADD16: begin
        fin_flags[FLAG_N] = 1'b0;
        fin_flags[FLAG_H] = alu_flags[FLAG_H];
        fin_flags[FLAG_C] = alu_flags[FLAG_C];
        fin_we            = 1'b1;
      end
      ADDSP: begin
        fin_flags[FLAG_Z] = 1'b0;
        fin_flags[FLAG_N] = 1'b0;
        fin_flags[FLAG_H] = lo_h_q;
        fin_flags[FLAG_C] = lo_c_q;
        fin_we            = 1'b1;
      end
      default: begin
        fin_we = 1'b0;
      end
    endcase
    fin_flags[3:0] = 4'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= ADD16;
      a_q       <= '0;
      b_q       <= '0;
      lo_q      <= '0;
      lo_h_q    <= 1'b0;
      lo_c_q    <= 1'b0;
      done      <= 1'b0;
      flags_we  <= 1'b0;
      result16  <= '0;
      flags_out <= '0;
    end else if (phi_en) begin
      done     <= 1'b0;
      flags_we <= 1'b0;
      if (accept) begin
        op_q <= req_op;
        a_q  <= req_a;
        b_q  <= seq16_operand_b(req_op, req_b);
      end
      if (state == ST_HI) begin
        lo_q   <= alu_result;
        lo_h_q <= alu_flags[FLAG_H];
        lo_c_q <= alu_flags[FLAG_C];
      end
      if (state == ST_FIN) begin
        result16  <= {alu_result, lo_q};
        flags_out <= fin_flags;
        flags_we  <= fin_we;
        done      <= 1'b1;
      end
    end
  end

endmodule
